dff_reg_arbiter: RTL and testbench
==================================

Name: dff_reg_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit master-slave register (q/qbar) among NREQ requesters.
- Each requester raises req and presents wdata. The arbiter issues a registered one-hot grant, and the granted requester's data is loaded into the register.
- Sits between multiple producer blocks and a shared DFF register bank. The register storage is owned by this block.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, shared register width
- HOLD_MAX, 4, max consecutive grant cycles while other requests are pending (>=1)

Ports:
- clk  input  1  system clock, rising edge
- clear  input  1  asynchronous active-low reset
- req  input  NREQ  request per requester, level
- wdata  input  NREQ*WIDTH  write data; slice i = wdata[i*WIDTH +: WIDTH]
- gnt  output  NREQ  registered one-hot grant
- q  output  WIDTH  shared register value
- qbar  output  WIDTH  bitwise complement of q, always ~q
- busy  output  1  high whenever any gnt bit is set
- lock  input  1  present only with DFF_ARB_LOCK_EN

Behaviour:
- Reset (clear=0, async, immediate): gnt=0, busy=0, q=0, qbar={WIDTH{1}}, rr_ptr=0, hold_cnt=0, state=IDLE.
- Reset mid-grant aborts the grant. No write occurs on any edge while clear=0.
- Arbitration picks the lowest index at or above rr_ptr, wrapping modulo NREQ, with req=1.
- After each grant ends, rr_ptr = granted index + 1, mod NREQ.
- State IDLE:
  - If any req is 1 at an edge: state->GRANT, gnt=onehot(winner), hold_cnt=1.
  - Otherwise stay in IDLE with gnt=0.
- State GRANT (owner k):
  - Write: at every edge with gnt[k]=1 and req[k]=1, q <= wdata slice k. This gives 1 cycle write latency after gnt is visible, and first write 2 edges after req is first sampled.
  - Release: if req[k]=0 at an edge, gnt clears on that edge. No write occurs, and rr_ptr advances.
    - If other requests are pending, re-arbitration happens in the same edge, giving a back-to-back grant to the next winner with no idle cycle.
    - Otherwise state->IDLE.
  - Preempt: if hold_cnt==HOLD_MAX and another req is pending at an edge:
    - The final write for k still occurs on that edge.
    - gnt moves to the next round-robin winner excluding k, and hold_cnt=1.
  - If no other req is pending, the grant continues past HOLD_MAX. hold_cnt saturates at HOLD_MAX.
- gnt is never multi-hot. busy = |gnt.
- Requests arriving for non-owners are ignored until re-arbitration. There is no request queueing beyond level req.
- Wrap-around: with rr_ptr=NREQ-1 and req[0] pending, the winner is 0.

Optional Feature:
- Macro: DFF_ARB_LOCK_EN.
- With the macro defined:
  - The lock input exists.
  - While gnt[k]=1 and lock=1, HOLD_MAX preemption is suppressed. The owner keeps the grant until its req drops.
  - lock is ignored when no grant is active.
- Without the macro: no lock port, and preemption always applies as above.

Test Plan:
- Reset: clear=0 with random req/wdata -> gnt=0, busy=0, q=8'h00, qbar=8'hFF. Release clear -> no write before the first grant.
- Single requester: req=4'b0010, wdata slice1=8'hA5 held -> gnt=4'b0010 one edge later, q=8'hA5 on the next edge, qbar=8'h5A. Drop req -> gnt=0 next edge.
- Round-robin order: req=4'b1111 each held one write, each dropping req after its first write -> grant order 0,1,2,3,0. Each q value matches the corresponding slice.
- Preemption: req0 and req2 held high, HOLD_MAX=4 -> gnt0 for exactly 4 cycles, then gnt2 for 4, then gnt0. With DFF_ARB_LOCK_EN and lock=1 during gnt0 -> gnt0 is held until req0 drops.
- Async reset mid-grant: clear pulsed low between edges while gnt=4'b0100 -> outputs reset immediately. After clear is released with req2 still high, a new grant goes to 2 (rr_ptr=0 scan), not index 3.
- Back-to-back release: owner 1 drops req while req3=1 -> gnt goes 4'b0010 to 4'b1000 in a single edge, and busy never deasserts.

Source files
------------

// File: rtl/dff_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dff_reg_arbiter
//  Description : Round-robin arbiter sharing one WIDTH-bit q/qbar register
//                among NREQ level requesters, with bounded grant hold.
//                Optional macro DFF_ARB_LOCK_EN adds a lock input that
//                suppresses hold-limit preemption for the current owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_reg_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic                    clk,
    input  logic                    clear,
`ifdef DFF_ARB_LOCK_EN
    input  logic                    lock,
`endif
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        q,
    output logic [WIDTH-1:0]        qbar,
    output logic                    busy
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_HC_W  = $clog2(HOLD_MAX + 1);

    localparam logic [0:0]          c_IDLE     = 1'b0;
    localparam logic [0:0]          c_GRANT    = 1'b1;
    localparam logic [c_HC_W-1:0]   c_HOLD_MAX = c_HC_W'(HOLD_MAX);
    localparam logic [c_HC_W-1:0]   c_HOLD_ONE = c_HC_W'(1);
    localparam logic [NREQ-1:0]     c_OH_ONE   = {{(NREQ-1){1'b0}}, 1'b1};

    logic [0:0]          r_state;
    logic [NREQ-1:0]     r_gnt;
    logic [c_PTR_W-1:0]  r_owner;
    logic [c_PTR_W-1:0]  r_rr_ptr;
    logic [c_HC_W-1:0]   r_hold;
    logic [WIDTH-1:0]    r_q;

    logic [0:0]          w_state_nxt;
    logic [NREQ-1:0]     w_gnt_nxt;
    logic [c_PTR_W-1:0]  w_owner_nxt;
    logic [c_PTR_W-1:0]  w_rr_nxt;
    logic [c_HC_W-1:0]   w_hold_nxt;
    logic [WIDTH-1:0]    w_q_nxt;

    logic [c_PTR_W-1:0]  w_arb_ptr;
    logic [NREQ-1:0]     w_arb_mask;
    logic [c_PTR_W-1:0]  w_winner;
    logic                w_found;
    logic [NREQ-1:0]     w_win_oh;
    logic [c_PTR_W-1:0]  w_owner_inc;
    logic                w_owner_req;
    logic [WIDTH-1:0]    w_wslice;
    logic                w_lock;
    logic                w_preempt;

`ifdef DFF_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_owner_inc = (r_owner == c_PTR_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;
    assign w_owner_req = |(req & r_gnt);
    assign w_win_oh    = c_OH_ONE << w_winner;
    assign w_preempt   = (r_hold == c_HOLD_MAX) && w_found && !w_lock;

    // While granted, the scan starts just past the owner and excludes it,
    // which serves both the release and the preemption hand-over.
    always_comb begin : p_arb
        int w_idx;
        w_idx      = 0;
        w_arb_ptr  = (r_state == c_GRANT) ? w_owner_inc : r_rr_ptr;
        w_arb_mask = (r_state == c_GRANT) ? (req & ~r_gnt) : req;
        w_found    = 1'b0;
        w_winner   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = int'(w_arb_ptr) + i;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && w_arb_mask[w_idx]) begin
                w_found  = 1'b1;
                w_winner = c_PTR_W'(w_idx);
            end
        end
    end

    always_comb begin
        w_wslice = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == c_PTR_W'(i)) begin
                w_wslice = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state  <= c_IDLE;
            r_gnt    <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_hold   <= '0;
            r_q      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_hold   <= w_hold_nxt;
            r_q      <= w_q_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_hold_nxt  = r_hold;
        w_q_nxt     = r_q;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_state_nxt = c_GRANT;
                    w_gnt_nxt   = w_win_oh;
                    w_owner_nxt = w_winner;
                    w_hold_nxt  = c_HOLD_ONE;
                end
            end
            c_GRANT: begin
                if (!w_owner_req) begin
                    w_rr_nxt = w_owner_inc;
                    if (w_found) begin
                        w_gnt_nxt   = w_win_oh;
                        w_owner_nxt = w_winner;
                        w_hold_nxt  = c_HOLD_ONE;
                    end else begin
                        w_state_nxt = c_IDLE;
                        w_gnt_nxt   = '0;
                        w_hold_nxt  = '0;
                    end
                end else begin
                    w_q_nxt = w_wslice;
                    if (w_preempt) begin
                        w_rr_nxt    = w_owner_inc;
                        w_gnt_nxt   = w_win_oh;
                        w_owner_nxt = w_winner;
                        w_hold_nxt  = c_HOLD_ONE;
                    end else if (r_hold != c_HOLD_MAX) begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_gnt_nxt   = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        gnt  = r_gnt;
        q    = r_q;
        qbar = ~r_q;
        busy = |r_gnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_dff_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dff_reg_arbiter
//  Description : Directed self-checking bench for dff_reg_arbiter
//                (NREQ=4, WIDTH=8, HOLD_MAX=4; lock case with DFF_ARB_LOCK_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_reg_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int HOLD_MAX = 4;

    logic                  clk;
    logic                  clear;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      qbar;
    logic                  busy;
`ifdef DFF_ARB_LOCK_EN
    logic                  lock;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    dff_reg_arbiter #(
        .NREQ     (NREQ),
        .WIDTH    (WIDTH),
        .HOLD_MAX (HOLD_MAX)
    ) u_dut (
        .clk   (clk),
        .clear (clear),
`ifdef DFF_ARB_LOCK_EN
        .lock  (lock),
`endif
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .q     (q),
        .qbar  (qbar),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic t_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b0;
        #2;
        clear = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_oh;
        logic [7:0] slice [4];
        int         order [5];

        clear = 1'b0;
        req   = 4'($urandom);
        wdata = $urandom;
`ifdef DFF_ARB_LOCK_EN
        lock  = 1'b0;
`endif
        // Reset held across edges with random inputs
        tick();
        tick();
        t_check("rst_gnt",  32'(gnt),  32'h0);
        t_check("rst_busy", 32'(busy), 32'h0);
        t_check("rst_q",    32'(q),    32'h00);
        t_check("rst_qbar", 32'(qbar), 32'hFF);
        clear = 1'b1;
        req   = 4'b0000;
        tick();
        t_check("post_rst_q",   32'(q),   32'h00);
        t_check("post_rst_gnt", 32'(gnt), 32'h0);

        // Single requester
        wdata = {8'h11, 8'h22, 8'hA5, 8'h44};
        req   = 4'b0010;
        tick();
        t_check("single_gnt",    32'(gnt),  32'h2);
        t_check("single_busy",   32'(busy), 32'h1);
        t_check("single_q_lat",  32'(q),    32'h00);
        tick();
        t_check("single_q",    32'(q),    32'hA5);
        t_check("single_qbar", 32'(qbar), 32'h5A);
        req = 4'b0000;
        tick();
        t_check("single_rel_gnt",  32'(gnt),  32'h0);
        t_check("single_rel_busy", 32'(busy), 32'h0);
        t_check("single_rel_q",    32'(q),    32'hA5);

        // Round-robin order from rr_ptr=0, including wrap 3 -> 0
        pulse_clear();
        slice[0] = 8'h09; slice[1] = 8'h1A; slice[2] = 8'h2B; slice[3] = 8'h3C;
        wdata    = {slice[3], slice[2], slice[1], slice[0]};
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            exp_oh = 4'b0001 << order[i];
            t_check($sformatf("rr_gnt%0d", i),  32'(gnt),  32'(exp_oh));
            t_check($sformatf("rr_busy%0d", i), 32'(busy), 32'h1);
            tick();
            t_check($sformatf("rr_q%0d", i), 32'(q), 32'(slice[order[i]]));
            req[order[i]] = 1'b0;
            tick();
            req[order[i]] = 1'b1;
        end
        req = 4'b0000;
        tick();
        tick();

        // Hold-limit preemption between requesters 0 and 2
        pulse_clear();
        wdata = {8'h00, 8'h7E, 8'h00, 8'hC3};
        req   = 4'b0101;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_oh = (e >= 5 && e <= 8) ? 4'b0100 : 4'b0001;
            t_check($sformatf("pre_gnt_e%0d", e), 32'(gnt), 32'(exp_oh));
            if (e == 5) t_check("pre_final_wr0", 32'(q), 32'hC3);
        end
        t_check("pre_final_wr2", 32'(q), 32'h7E);
        req = 4'b0000;
        tick();

`ifdef DFF_ARB_LOCK_EN
        // Lock suppresses preemption until owner drops req
        pulse_clear();
        lock = 1'b1;
        req  = 4'b0101;
        for (int e = 1; e <= 8; e++) begin
            tick();
            t_check($sformatf("lock_gnt_e%0d", e), 32'(gnt), 32'h1);
        end
        req = 4'b0100;
        tick();
        t_check("lock_rel_gnt", 32'(gnt), 32'h4);
        lock = 1'b0;
        req  = 4'b0000;
        tick();
        tick();
`endif

        // Async reset mid-grant with rr_ptr pushed to 3 beforehand
        pulse_clear();
        wdata = {8'h00, 8'h5C, 8'h00, 8'h00};
        req   = 4'b0100;
        tick();
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        t_check("mid_pre_gnt", 32'(gnt), 32'h4);
        t_check("mid_pre_q",   32'(q),   32'h5C);
        req = 4'b1100;
        #2;
        clear = 1'b0;
        #1;
        t_check("mid_rst_gnt",  32'(gnt),  32'h0);
        t_check("mid_rst_busy", 32'(busy), 32'h0);
        t_check("mid_rst_q",    32'(q),    32'h00);
        t_check("mid_rst_qbar", 32'(qbar), 32'hFF);
        tick();
        t_check("mid_rst_hold_q",   32'(q),   32'h00);
        t_check("mid_rst_hold_gnt", 32'(gnt), 32'h0);
        clear = 1'b1;
        tick();
        t_check("mid_regrant", 32'(gnt), 32'h4);
        req = 4'b0000;
        tick();
        tick();

        // Back-to-back hand-over from owner 1 to requester 3
        pulse_clear();
        req = 4'b0010;
        tick();
        t_check("b2b_gnt1", 32'(gnt), 32'h2);
        req = 4'b1010;
        tick();
        t_check("b2b_hold_gnt",  32'(gnt),  32'h2);
        t_check("b2b_hold_busy", 32'(busy), 32'h1);
        req = 4'b1000;
        tick();
        t_check("b2b_gnt3", 32'(gnt),  32'h8);
        t_check("b2b_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        tick();
        tick();
        t_check("b2b_idle", 32'(gnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
